// File: rtl/frame_snapshot_pkg.sv
// Shared types and default sizing for the frame snapshot controller.
package frame_snapshot_pkg;

   // Snapshot sequencing states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      READY  = 2'd2,
      LOAD   = 2'd3
   } snap_state_t;

   localparam int unsigned SETTLE_CYC_DEF = 8;
   localparam int unsigned CNT_W_DEF      = 16;
   localparam int unsigned SAT_W_DEF      = 8;

endpackage : frame_snapshot_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; both stages exposed so callers can spot an edge still in flight.
module sync_2ff #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q1,
   output logic [W-1:0] q2
);

   // Synchronizer chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1 <= '0;
         q2 <= '0;
      end else begin
         q1 <= d;
         q2 <= q1;
      end
   end

endmodule : sync_2ff

// File: rtl/frame_snapshot_ctrl.sv
// Issues one shadow-register load strobe per vertical blank, once new game state has settled.
module frame_snapshot_ctrl
   import frame_snapshot_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned SAT_W      = SAT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             game_tick,
   input  logic             vs,
   input  logic             enable,
   output logic             snap_en,
   output logic             pending,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [SAT_W-1:0] drop_cnt,
   output logic [SAT_W-1:0] miss_cnt
);

   localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

   snap_state_t      state, state_next;
   logic [SET_W-1:0] cnt, cnt_next;
   logic             drop_inc;

   logic t1, t2, t3;
   logic v1_unused, v2;
   logic tick_rise, in_flight, vb, vb_q, vb_fall, vb_done, miss_hit;

   // Bring the game clock into the pixel domain
   sync_2ff #(.W(1)) u_sync_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (game_tick),
      .q1    (t1),
      .q2    (t2)
   );

   // Bring vertical sync into the pixel domain; its first stage is not needed here
   sync_2ff #(.W(1)) u_sync_vs (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (vs),
      .q1    (v1_unused),
      .q2    (v2)
   );

   assign tick_rise = t2 & ~t3;
   assign in_flight = t1 ^ t2;
   assign vb        = ~v2;
   assign vb_fall   = vb_q & ~vb;
   // A vblank that ends while a loaded-nothing state is waiting counts as a miss
   assign miss_hit  = vb_fall & ~vb_done & ((state == SETTLE) | (state == READY));

   // Edge-detect delay flops and per-vblank load lockout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t3      <= 1'b0;
         vb_q    <= 1'b0;
         vb_done <= 1'b0;
      end else begin
         t3   <= t2;
         vb_q <= vb;
         if (vb_fall) begin
            vb_done <= 1'b0;
         end else if (state == LOAD) begin
            vb_done <= 1'b1;
         end
      end
   end

   // State and settle counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic: settle new game state, then load once inside vblank
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      drop_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (tick_rise) begin
               state_next = SETTLE;
               cnt_next   = '0;
            end
         end
         SETTLE: begin
            if (tick_rise) begin
               cnt_next = '0;
            end else if (cnt == SET_LAST) begin
               state_next = READY;
            end else begin
               cnt_next = cnt + SET_W'(1);
            end
         end
         READY: begin
            if (tick_rise) begin
               state_next = SETTLE;
               cnt_next   = '0;
               drop_inc   = 1'b1;
            end else if (vb && !vb_done && enable && !in_flight) begin
               state_next = LOAD;
            end else if (vb && in_flight) begin
               // a game edge is racing the load; wait for it to settle
               state_next = SETTLE;
               cnt_next   = '0;
            end
         end
         LOAD: begin
            if (tick_rise) begin
               state_next = SETTLE;
               cnt_next   = '0;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Registered strobe and status, aligned with the state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_en <= 1'b0;
         pending <= 1'b0;
      end else begin
         snap_en <= (state_next == LOAD);
         pending <= (state_next != IDLE);
      end
   end

   // Load count wraps; drop and miss counts saturate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         drop_cnt  <= '0;
         miss_cnt  <= '0;
      end else begin
         if (state == LOAD) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
         if (drop_inc && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + SAT_W'(1);
         end
         if (miss_hit && (miss_cnt != '1)) begin
            miss_cnt <= miss_cnt + SAT_W'(1);
         end
      end
   end

endmodule : frame_snapshot_ctrl

// File: tb/tb_frame_snapshot_ctrl.sv
// Scoreboard bench for frame_snapshot_ctrl: expected load strobes are queued by the stimulus
// and consumed by a monitor whenever snap_en is seen.
module tb_frame_snapshot_ctrl;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned SAT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             game_tick;
   logic             vs;
   logic             enable;
   logic             snap_en;
   logic             pending;
   logic [CNT_W-1:0] frame_cnt;
   logic [SAT_W-1:0] drop_cnt;
   logic [SAT_W-1:0] miss_cnt;

   typedef struct {
      int cyc;
      int frame;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   exp_frame = 0;
   int   c0;

   frame_snapshot_ctrl #(.SETTLE_CYC(8), .CNT_W(CNT_W), .SAT_W(SAT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .game_tick (game_tick),
      .vs        (vs),
      .enable    (enable),
      .snap_en   (snap_en),
      .pending   (pending),
      .frame_cnt (frame_cnt),
      .drop_cnt  (drop_cnt),
      .miss_cnt  (miss_cnt)
   );

   always #20 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Queue a strobe expected a fixed number of cycles from now
   task automatic expect_snap(input int delay);
      exp_t e;
      e.cyc   = cyc + delay;
      e.frame = exp_frame;
      q.push_back(e);
      exp_frame++;
   endtask

   // Wait (bounded) for every queued strobe to be consumed
   task automatic drain(input int budget);
      for (int i = 0; i < budget && q.size() > 0; i++) @(negedge clk);
      check("snap_arrived", int'(q.size() == 0), 1);
      q.delete();
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && snap_en === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_snap: got snap_en=1 expected 0 (cycle %0d)", cyc);
            end else begin
               e = q.pop_front();
               check("snap_cycle", cyc, e.cyc);
               check("snap_frame_cnt", int'(frame_cnt), e.frame);
               check("snap_pending", int'(pending), 1);
            end
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      game_tick = 1'b0;
      vs        = 1'b1;
      enable    = 1'b1;
      fork
         monitor();
      join_none

      // Reset, then two idle frames with no strobe
      wait_clks(4);
      rst_n = 1'b1;
      wait_clks(5);
      check("rst_snap_en", int'(snap_en), 0);
      check("rst_pending", int'(pending), 0);
      check("rst_frame_cnt", int'(frame_cnt), 0);
      check("rst_drop_cnt", int'(drop_cnt), 0);
      check("rst_miss_cnt", int'(miss_cnt), 0);
      repeat (2) begin
         wait_clks(300);
         vs = 1'b0;
         wait_clks(40);
         vs = 1'b1;
      end
      wait_clks(50);
      check("idle_frame_cnt", int'(frame_cnt), 0);

      // Tick in active video, vblank 1000 clocks later
      c0 = cyc;
      game_tick = 1'b1;
      wait_clks(2);
      check("t2_pending_early", int'(pending), 0);
      wait_clks(1);
      check("t2_pending_3clk", int'(pending), 1);
      wait_clks(17);
      game_tick = 1'b0;
      wait_clks(1000 - (cyc - c0));
      vs = 1'b0;
      expect_snap(3);
      wait_clks(40);
      vs = 1'b1;
      drain(10);
      wait_clks(5);
      check("t2_pending_after", int'(pending), 0);
      check("t2_frame_cnt", int'(frame_cnt), 1);
      check("t2_miss_cnt", int'(miss_cnt), 0);

      // Tick two clocks into vblank: load in the same vblank
      wait_clks(100);
      vs = 1'b0;
      wait_clks(2);
      game_tick = 1'b1;
      expect_snap(12);
      wait_clks(20);
      game_tick = 1'b0;
      wait_clks(18);
      vs = 1'b1;
      drain(10);
      wait_clks(5);
      check("t3_miss_cnt", int'(miss_cnt), 0);
      check("t3_frame_cnt", int'(frame_cnt), 2);

      // Three ticks before one vblank: two drops, one load
      wait_clks(50);
      for (int i = 0; i < 3; i++) begin
         game_tick = 1'b1;
         wait_clks(20);
         game_tick = 1'b0;
         wait_clks(80);
      end
      check("t4_drop_cnt", int'(drop_cnt), 2);
      vs = 1'b0;
      expect_snap(3);
      wait_clks(40);
      vs = 1'b1;
      drain(10);
      wait_clks(5);
      check("t4_frame_cnt", int'(frame_cnt), 3);
      check("t4_pending", int'(pending), 0);

      // Disabled through a whole vblank, then re-enabled mid-vblank
      enable = 1'b0;
      game_tick = 1'b1;
      wait_clks(20);
      game_tick = 1'b0;
      wait_clks(20);
      vs = 1'b0;
      wait_clks(40);
      vs = 1'b1;
      wait_clks(5);
      check("t5_miss_cnt", int'(miss_cnt), 1);
      check("t5_pending_held", int'(pending), 1);
      check("t5_frame_hold", int'(frame_cnt), 3);
      wait_clks(100);
      vs = 1'b0;
      wait_clks(10);
      enable = 1'b1;
      expect_snap(1);
      wait_clks(30);
      vs = 1'b1;
      drain(10);
      wait_clks(5);
      check("t5_frame_cnt", int'(frame_cnt), 4);
      check("t5_miss_after", int'(miss_cnt), 1);

      // Drop counter saturation
      for (int i = 0; i < 260; i++) begin
         game_tick = 1'b1;
         wait_clks(15);
         game_tick = 1'b0;
         wait_clks(15);
      end
      check("t6_drop_sat", int'(drop_cnt), 255);
      check("t6_miss_cnt", int'(miss_cnt), 1);

      // Reset while settling discards the captured state
      wait_clks(20);
      game_tick = 1'b1;
      wait_clks(6);
      rst_n = 1'b0;
      #1;
      check("rstmid_pending", int'(pending), 0);
      check("rstmid_snap_en", int'(snap_en), 0);
      check("rstmid_drop_cnt", int'(drop_cnt), 0);
      check("rstmid_frame_cnt", int'(frame_cnt), 0);
      game_tick = 1'b0;
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(20);
      vs = 1'b0;
      wait_clks(40);
      vs = 1'b1;
      wait_clks(10);
      check("rstmid_pending_after", int'(pending), 0);
      check("rstmid_frame_after", int'(frame_cnt), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_frame_snapshot_ctrl
